// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: captures operand A, then operand B plus opcode, from a shared
// switch bus. It offers them to the compute stage over a valid/ready handshake and
// counts completed transfers.
// Optional feature: define CALC_LOAD_EDGE_EN to turn a held load into a single rising-edge
// event. When undefined, every edge with load high is an event.
module calc_operand_sequencer #(
    parameter int unsigned bits    = 8,
    parameter int unsigned op_bits = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [bits-1:0]    din,
    input  logic [op_bits-1:0] op_in,
    input  logic               load,
    input  logic               clear,
    output logic [bits-1:0]    out_a,
    output logic [bits-1:0]    out_b,
    output logic [op_bits-1:0] out_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         state,
    output logic [7:0]         issue_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StHaveA = 2'b01,
        StIssue = 2'b10,
        StBad   = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [bits-1:0]    a_q, b_q;
    logic [op_bits-1:0] op_q;
    logic [7:0]         cnt_q;
    logic               load_evt;
    logic               xfer;

`ifdef CALC_LOAD_EDGE_EN
    logic load_q;

    // Previous load level for rising-edge detection; keeps tracking through clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 1'b0;
        end else begin
            load_q <= load;
        end
    end

    assign load_evt = load & ~load_q;
`else
    assign load_evt = load;
`endif

    // A transfer is counted even when clear lands on the same edge.
    assign xfer = (state_q == StIssue) & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything and the unused encoding recovers.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (load_evt) state_d = StHaveA;
                StHaveA: if (load_evt) state_d = StIssue;
                StIssue: if (out_ready) state_d = StEmpty;
                default: state_d = StEmpty;
            endcase
        end
    end

    // Output decode: valid depends on state only, never on out_ready.
    always_comb begin
        out_valid = (state_q == StIssue);
        state     = state_q;
    end

    // Operand/opcode capture; values hold after a transfer until overwritten or cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (clear) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (load_evt && state_q == StEmpty) begin
            a_q <= din;
        end else if (load_evt && state_q == StHaveA) begin
            b_q  <= din;
            op_q <= op_in;
        end
    end

    // Completed-transfer counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_op    = op_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer with a scoreboard of expected issues.
module tb_calc_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [2:0] op_in;
    logic       load;
    logic       clear;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [2:0] out_op;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] state;
    logic [7:0] issue_cnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    calc_operand_sequencer #(
        .bits    (8),
        .op_bits (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .op_in     (op_in),
        .load      (load),
        .clear     (clear),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (state),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input logic [2:0] o);
        din   = d;
        op_in = o;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Pop the oldest expected issue and compare against what the DUT is offering.
    task automatic check_issue(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_a"}, 32'(out_a), 32'(e.a));
            chk({tag, "_b"}, 32'(out_b), 32'(e.b));
            chk({tag, "_op"}, 32'(out_op), 32'(e.op));
        end
    endtask

    // Load A, idle one cycle, load B/op; leaves the DUT offering in ISSUE.
    task automatic do_issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op);
        exp_t e;
        pulse(a, 3'd0);
        chk({tag, "_state_a"}, 32'(state), 32'd1);
        chk({tag, "_cap_a"}, 32'(out_a), 32'(a));
        tick();
        e.a  = a;
        e.b  = b;
        e.op = op;
        sb.push_back(e);
        pulse(b, op);
        chk({tag, "_state_issue"}, 32'(state), 32'd2);
        check_issue(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 8'd0;
        op_in     = 3'd0;
        load      = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", 32'(out_a), 32'd0);
        chk("rst_b", 32'(out_b), 32'd0);
        chk("rst_op", 32'(out_op), 32'd0);
        chk("rst_cnt", 32'(issue_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic issue with ready held high.
        out_ready = 1'b1;
        do_issue("basic", 8'h12, 8'h34, 3'd5);
        tick();
        exp_cnt++;
        chk("basic_valid_drop", 32'(out_valid), 32'd0);
        chk("basic_state", 32'(state), 32'd0);
        chk("basic_cnt", 32'(issue_cnt), 32'(exp_cnt));
        chk("basic_hold_a", 32'(out_a), 32'h12);

        // Backpressure with load noise; outputs must hold.
        out_ready = 1'b0;
        do_issue("bp", 8'hA5, 8'h5A, 3'd3);
        for (int i = 0; i < 10; i++) begin
            din   = 8'($urandom);
            op_in = 3'($urandom);
            load  = ~i[0];
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_a", 32'(out_a), 32'hA5);
            chk("bp_b", 32'(out_b), 32'h5A);
            chk("bp_op", 32'(out_op), 32'd3);
        end
        // Load on the accepting edge is ignored.
        out_ready = 1'b1;
        din       = 8'h77;
        load      = 1'b1;
        tick();
        exp_cnt++;
        load      = 1'b0;
        out_ready = 1'b0;
        chk("bp_accept_state", 32'(state), 32'd0);
        chk("bp_accept_cnt", 32'(issue_cnt), 32'(exp_cnt));
        chk("bp_accept_a_kept", 32'(out_a), 32'hA5);
        tick();
        chk("bp_single_cnt", 32'(issue_cnt), 32'(exp_cnt));
        chk("bp_idle_state", 32'(state), 32'd0);

        // Clear while holding A.
        pulse(8'h3C, 3'd0);
        chk("clr_havea_state", 32'(state), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_a", 32'(out_a), 32'd0);
        chk("clr_cnt", 32'(issue_cnt), 32'(exp_cnt));

        // Clear coinciding with an accepted transfer still counts it.
        out_ready = 1'b1;
        do_issue("clrx", 8'h11, 8'h22, 3'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_cnt++;
        chk("clrx_cnt", 32'(issue_cnt), 32'(exp_cnt));
        chk("clrx_state", 32'(state), 32'd0);
        chk("clrx_b", 32'(out_b), 32'd0);
        chk("clrx_op", 32'(out_op), 32'd0);

        // Clear while offering without ready: no count.
        out_ready = 1'b0;
        do_issue("clrn", 8'h66, 8'h99, 3'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrn_cnt", 32'(issue_cnt), 32'(exp_cnt));
        chk("clrn_valid", 32'(out_valid), 32'd0);

        // Load held high for five edges.
        din   = 8'h44;
        op_in = 3'd1;
        load  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        load = 1'b0;
`ifdef CALC_LOAD_EDGE_EN
        chk("held_state", 32'(state), 32'd1);
        chk("held_a", 32'(out_a), 32'h44);
`else
        chk("held_state", 32'(state), 32'd2);
        chk("held_a", 32'(out_a), 32'h44);
        chk("held_b", 32'(out_b), 32'h44);
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("held_clr_cnt", 32'(issue_cnt), 32'(exp_cnt));

        // Run issues until the counter wraps to zero.
        out_ready = 1'b1;
        while (exp_cnt != 8'd0) begin
            do_issue("wrap", 8'($urandom), 8'($urandom), 3'($urandom));
            tick();
            exp_cnt++;
            chk("wrap_cnt", 32'(issue_cnt), 32'(exp_cnt));
        end
        chk("wrap_zero", 32'(issue_cnt), 32'd0);

        // Asynchronous reset between edges while offering.
        out_ready = 1'b0;
        do_issue("arst", 8'hC3, 8'h3C, 3'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_a", 32'(out_a), 32'd0);
        chk("arst_b", 32'(out_b), 32'd0);
        chk("arst_op", 32'(out_op), 32'd0);
        chk("arst_cnt", 32'(issue_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after_state", 32'(state), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
